// File: rtl/snd_voice_sink.sv
// Four-voice square-wave tone generator driven by CPU register writes.
// A sample-rate prescaler advances each voice's phase and mixes enabled voices into an unsigned PCM sample.
module snd_voice_sink #(
   parameter int CLK_DIV = 1042,
   parameter int DUR_DIV = 48
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        snd_wen,
   input  logic [1:0]  w_param,
   input  logic [10:0] w_index,
   input  logic [15:0] w_val,
   output logic        sample_strobe,
   output logic [5:0]  audio_out,
   output logic [3:0]  voice_active
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int DW = (DUR_DIV > 1) ? $clog2(DUR_DIV) : 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DUR_LAST = DW'(DUR_DIV - 1);

   localparam logic [1:0] P_PERIOD   = 2'd0;
   localparam logic [1:0] P_VOLUME   = 2'd1;
   localparam logic [1:0] P_DURATION = 2'd2;
   localparam logic [1:0] P_CONTROL  = 2'd3;

   logic [CW-1:0]      div_q, div_d;
   logic [DW-1:0]      dcnt_q, dcnt_d;
   logic [3:0][15:0]   period_q, period_d;
   logic [3:0][3:0]    volume_q, volume_d;
   logic [3:0][15:0]   dur_q, dur_d;
   logic [3:0][15:0]   phase_q, phase_d;
   logic [3:0]         active_q, active_d;
   logic [3:0]         level_q, level_d;
   logic [5:0]         audio_q, audio_d;

   logic strobe, dur_tick, wr_ok;
   logic [5:0] mix;

   assign strobe   = (div_q == CLK_LAST);
   assign dur_tick = strobe && (dcnt_q == DUR_LAST);
   assign wr_ok    = snd_wen && (w_index[10:2] == 9'd0);

   always_comb begin
      div_d  = strobe ? '0 : div_q + 1'b1;
      dcnt_d = dcnt_q;
      if (strobe) dcnt_d = dur_tick ? '0 : dcnt_q + 1'b1;
   end

   // Mix uses pre-update levels, so the output lags the phase state by one sample.
   always_comb begin
      mix = '0;
      for (int v = 0; v < 4; v++) begin
         if (active_q[v] && (period_q[v] != 16'd0) && level_q[v])
            mix = mix + {2'b00, volume_q[v]};
      end
      audio_d = strobe ? mix : audio_q;
   end

   always_comb begin
      period_d = period_q;
      volume_d = volume_q;
      dur_d    = dur_q;
      phase_d  = phase_q;
      active_d = active_q;
      level_d  = level_q;
      for (int v = 0; v < 4; v++) begin
         if (strobe && active_q[v] && (period_q[v] != 16'd0)) begin
            if (({1'b0, phase_q[v]} + 17'd1) >= {1'b0, period_q[v]}) begin
               phase_d[v] = 16'd0;
               level_d[v] = ~level_q[v];
            end else begin
               phase_d[v] = phase_q[v] + 16'd1;
            end
         end
         if (dur_tick && active_q[v] && (dur_q[v] != 16'd0)) begin
            dur_d[v] = dur_q[v] - 16'd1;
            if (dur_q[v] == 16'd1) active_d[v] = 1'b0;
         end
         // A write owns its field; a DURATION load or a disable also cancels that edge's countdown.
         if (wr_ok && (w_index[1:0] == 2'(v))) begin
            case (w_param)
               P_PERIOD:   period_d[v] = w_val;
               P_VOLUME:   volume_d[v] = w_val[3:0];
               P_DURATION: begin
                  dur_d[v]    = w_val;
                  active_d[v] = active_q[v];
               end
               P_CONTROL:  begin
                  active_d[v] = w_val[0];
                  if (!w_val[0]) dur_d[v] = dur_q[v];
                  if (w_val[1]) begin
                     phase_d[v] = 16'd0;
                     level_d[v] = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q    <= '0;
         dcnt_q   <= '0;
         period_q <= '0;
         volume_q <= '0;
         dur_q    <= '0;
         phase_q  <= '0;
         active_q <= '0;
         level_q  <= '0;
         audio_q  <= '0;
      end else begin
         div_q    <= div_d;
         dcnt_q   <= dcnt_d;
         period_q <= period_d;
         volume_q <= volume_d;
         dur_q    <= dur_d;
         phase_q  <= phase_d;
         active_q <= active_d;
         level_q  <= level_d;
         audio_q  <= audio_d;
      end
   end

   assign sample_strobe = strobe;
   assign audio_out     = audio_q;
   assign voice_active  = active_q;

endmodule

// File: tb/tb_snd_voice_sink.sv
// Directed bench for snd_voice_sink with a short sample period (CLK_DIV=4, DUR_DIV=2).
module tb_snd_voice_sink;

   logic        clk;
   logic        resetn;
   logic        snd_wen;
   logic [1:0]  w_param;
   logic [10:0] w_index;
   logic [15:0] w_val;
   logic        sample_strobe;
   logic [5:0]  audio_out;
   logic [3:0]  voice_active;

   int vectors;
   int miscompares;

   snd_voice_sink #(.CLK_DIV(4), .DUR_DIV(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .snd_wen      (snd_wen),
      .w_param      (w_param),
      .w_index      (w_index),
      .w_val        (w_val),
      .sample_strobe(sample_strobe),
      .audio_out    (audio_out),
      .voice_active (voice_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_audio(input string tag, input logic [5:0] exp);
      chk(tag, {10'd0, audio_out}, {10'd0, exp});
   endtask

   task automatic chk_active(input string tag, input logic [3:0] exp);
      chk(tag, {12'd0, voice_active}, {12'd0, exp});
   endtask

   task automatic wr(input logic [1:0] p, input logic [10:0] idx, input logic [15:0] val);
      snd_wen = 1'b1;
      w_param = p;
      w_index = idx;
      w_val   = val;
      @(negedge clk);
      snd_wen = 1'b0;
   endtask

   // Returns one negedge after the strobe edge has been taken.
   task automatic wait_strobe(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (sample_strobe === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed no sample_strobe expected one within 16 cycles", tag);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      resetn  = 1'b0;
      snd_wen = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_strobe", {15'd0, sample_strobe}, 16'd0);
      chk_audio("rst_audio", 6'd0);
      chk_active("rst_active", 4'd0);
      resetn = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      resetn      = 1'b0;
      snd_wen     = 1'b0;
      w_param     = 2'd0;
      w_index     = 11'd0;
      w_val       = 16'd0;

      // 1: idle strobe cadence
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         chk("t1_strobe", {15'd0, sample_strobe}, (i % 4 == 3) ? 16'd1 : 16'd0);
      end
      chk_audio("t1_audio", 6'd0);
      chk_active("t1_active", 4'd0);

      // 2: voice0 half-period 2, volume 15
      do_reset();
      wr(2'd0, 11'd0, 16'd2);
      wr(2'd1, 11'd0, 16'd15);
      wr(2'd3, 11'd0, 16'd3);
      chk_active("t2_active", 4'b0001);
      wait_strobe("t2_s1"); chk_audio("t2_s1", 6'd15);
      wait_strobe("t2_s2"); chk_audio("t2_s2", 6'd15);
      wait_strobe("t2_s3"); chk_audio("t2_s3", 6'd0);
      wait_strobe("t2_s4"); chk_audio("t2_s4", 6'd0);
      wait_strobe("t2_s5"); chk_audio("t2_s5", 6'd15);
      wait_strobe("t2_s6"); chk_audio("t2_s6", 6'd15);

      // 3: voice1 duration 3 ticks, enable aligned to a duration-tick boundary
      do_reset();
      wr(2'd0, 11'd1, 16'd100);
      wr(2'd1, 11'd1, 16'd5);
      wr(2'd2, 11'd1, 16'd3);
      wait_strobe("t3_pre1");
      wait_strobe("t3_pre2");
      wr(2'd3, 11'd1, 16'd3);
      chk_active("t3_en", 4'b0010);
      wait_strobe("t3_s1"); chk_audio("t3_s1", 6'd5);
      wait_strobe("t3_s2");
      wait_strobe("t3_s3");
      wait_strobe("t3_s4");
      wait_strobe("t3_s5"); chk_active("t3_s5_act", 4'b0010);
      wait_strobe("t3_s6"); chk_active("t3_s6_act", 4'b0000);
      chk_audio("t3_s6_audio", 6'd5);
      wait_strobe("t3_s7"); chk_audio("t3_s7_audio", 6'd0);

      // 4: all voices full volume, then voice2 volume with upper bits set
      do_reset();
      for (int v = 0; v < 4; v++) begin
         wr(2'd0, 11'(v), 16'd1000);
         wr(2'd1, 11'(v), 16'd15);
         wr(2'd3, 11'(v), 16'd3);
      end
      wait_strobe("t4_all");
      chk_audio("t4_all", 6'd60);
      chk_active("t4_act", 4'b1111);
      wr(2'd1, 11'd2, 16'h00F7);
      wait_strobe("t4_v2");
      chk_audio("t4_v2", 6'd52);

      // 5: out-of-range voice indices are ignored
      for (int p = 0; p < 4; p++) begin
         wr(2'(p), 11'h004, 16'd0);
         wr(2'(p), 11'h404, 16'd0);
      end
      chk_active("t5_act", 4'b1111);
      wait_strobe("t5_mix");
      chk_audio("t5_mix", 6'd52);

      // 6: asynchronous reset mid-tone
      do_reset();
      wr(2'd0, 11'd0, 16'd1000);
      wr(2'd1, 11'd0, 16'd15);
      wr(2'd3, 11'd0, 16'd3);
      wait_strobe("t6_tone");
      chk_audio("t6_tone", 6'd15);
      #2 resetn = 1'b0;
      #1;
      chk_audio("t6_async_audio", 6'd0);
      chk_active("t6_async_act", 4'd0);
      chk("t6_async_strobe", {15'd0, sample_strobe}, 16'd0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("t6_strobe", {15'd0, sample_strobe}, (i == 3) ? 16'd1 : 16'd0);
      end
      chk_audio("t6_after", 6'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
